dmi_regbus_bridge: RTL and testbench

DMI_REGBUS_BRIDGE -- requirements
Module: dmi_regbus_bridge

---
 rtl/dm_pkg.sv | 25 ++
 rtl/dmi_regbus_bridge.sv | 128 ++++++++++++
 tb/tb_dmi_regbus_bridge.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Debug-module transport types shared by DMI clients and bridges.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_regbus_bridge.sv
// Bridges single DMI transactions onto a req/gnt/rvalid register bus, with an optional
// watchdog that aborts stuck bus transfers and discards their late responses.
module dmi_regbus_bridge
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  dmi_req_t    dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output dmi_resp_t   dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic        reg_req_o,
    output logic        reg_we_o,
    output logic [6:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_gnt_i,
    input  logic        reg_rvalid_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_err_i
);

    localparam int unsigned CntW    = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam int unsigned TmoLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp,
        StResp
    } state_e;

    state_e          state_q;
    logic            stale_q;
    logic [CntW-1:0] cnt_q;
    logic            we_q;
    logic [6:0]      addr_q;
    logic [31:0]     wdata_q;
    dmi_resp_t       resp_q;
    logic            timeout_hit;

    // The edge ending the TimeoutCycles-th busy cycle is the abort point.
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntW'(TmoLast));

    assign dmi_req_ready_o  = rst_ni && (state_q == StIdle) && !stale_q;
    assign dmi_resp_valid_o = (state_q == StResp);
    assign dmi_resp_o       = resp_q;
    assign reg_req_o        = (state_q == StReq);
    assign reg_we_o         = we_q;
    assign reg_addr_o       = addr_q;
    assign reg_wdata_o      = wdata_q;

    // Transaction FSM with watchdog counter, latched request fields and response register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            stale_q <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
        end else begin
            // A response belonging to an aborted transfer is swallowed here.
            if (stale_q && reg_rvalid_i) begin
                stale_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (dmi_req_valid_i && dmi_req_ready_o) begin
                        addr_q  <= dmi_req_i.addr;
                        wdata_q <= dmi_req_i.data;
                        we_q    <= (dmi_req_i.op == DTM_WRITE);
                        cnt_q   <= '0;
                        case (dmi_req_i.op)
                            DTM_NOP: begin
                                resp_q  <= '{data: 32'h0, resp: DTM_SUCCESS};
                                state_q <= StResp;
                            end
                            DTM_READ, DTM_WRITE: begin
                                state_q <= StReq;
                            end
                            default: begin
                                resp_q  <= '{data: 32'h0, resp: DTM_ERR};
                                state_q <= StResp;
                            end
                        endcase
                    end
                end
                StReq: begin
                    if (cnt_q != CntMax) cnt_q <= cnt_q + CntW'(1);
                    if (reg_gnt_i && timeout_hit) begin
                        // Granted at the abort point: the bus still owes a response.
                        resp_q  <= '{data: 32'h0, resp: DTM_ERR};
                        stale_q <= 1'b1;
                        state_q <= StResp;
                    end else if (reg_gnt_i) begin
                        state_q <= StWaitRsp;
                    end else if (timeout_hit) begin
                        resp_q  <= '{data: 32'h0, resp: DTM_ERR};
                        state_q <= StResp;
                    end
                end
                StWaitRsp: begin
                    if (cnt_q != CntMax) cnt_q <= cnt_q + CntW'(1);
                    // A response arriving on the abort edge still wins.
                    if (reg_rvalid_i) begin
                        resp_q.data <= we_q ? 32'h0 : reg_rdata_i;
                        resp_q.resp <= reg_err_i ? DTM_ERR : DTM_SUCCESS;
                        state_q     <= StResp;
                    end else if (timeout_hit) begin
                        resp_q  <= '{data: 32'h0, resp: DTM_ERR};
                        stale_q <= 1'b1;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (dmi_resp_ready_i) state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_regbus_bridge.sv
// Self-checking bench: directed vector table, randomized transactions against a
// cycle-count reference model, and a reset-during-transfer sequence.
module tb_dmi_regbus_bridge;
    import dm::*;

    localparam int Tmo = 4;

    logic        clk;
    logic        rst_ni;
    dmi_req_t    dmi_req_i;
    logic        dmi_req_valid_i;
    logic        dmi_req_ready_o;
    dmi_resp_t   dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [6:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_gnt_i;
    logic        reg_rvalid_i;
    logic [31:0] reg_rdata_i;
    logic        reg_err_i;

    int n_checks = 0;
    int n_pass   = 0;
    int txn_id   = 0;

    dmi_regbus_bridge #(.TimeoutCycles(Tmo)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .dmi_req_i        (dmi_req_i),
        .dmi_req_valid_i  (dmi_req_valid_i),
        .dmi_req_ready_o  (dmi_req_ready_o),
        .dmi_resp_o       (dmi_resp_o),
        .dmi_resp_valid_o (dmi_resp_valid_o),
        .dmi_resp_ready_i (dmi_resp_ready_i),
        .reg_req_o        (reg_req_o),
        .reg_we_o         (reg_we_o),
        .reg_addr_o       (reg_addr_o),
        .reg_wdata_o      (reg_wdata_o),
        .reg_gnt_i        (reg_gnt_i),
        .reg_rvalid_i     (reg_rvalid_i),
        .reg_rdata_i      (reg_rdata_i),
        .reg_err_i        (reg_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
        int          g;      // cycles in Req before the grant
        int          r;      // cycles in WaitRsp before rvalid
        logic        err;
        logic [31:0] rdata;
        int          hold;   // cycles dmi_resp_ready_i stays low once valid
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (txn %0d): got %0h, expected %0h", name, txn_id, act, exp);
    endtask

    // Response the bridge owes, from the total number of busy cycles vs the timeout.
    function automatic dmi_resp_t model_resp(input logic [1:0] op, input int g, input int r,
                                             input logic err, input logic [31:0] rdata);
        dmi_resp_t res;
        if (op == 2'd0) res = '{data: 32'h0, resp: DTM_SUCCESS};
        else if (op == 2'd3) res = '{data: 32'h0, resp: DTM_ERR};
        else if (g + r + 2 <= Tmo)
            res = '{data: (op == 2'd1) ? rdata : 32'h0, resp: err ? DTM_ERR : DTM_SUCCESS};
        else res = '{data: 32'h0, resp: DTM_ERR};
        return res;
    endfunction

    task automatic run_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                           input int g, input int r, input logic err, input logic [31:0] rdata,
                           input int hold, input dmi_resp_t exp);
        bit bus, granted, real_rsp, stale;
        int t_valid, t_hs, t_rv, last_req, end_c;
        bus      = (op == 2'd1) || (op == 2'd2);
        granted  = bus && (g <= Tmo - 1);
        real_rsp = bus && (g + r + 2 <= Tmo);
        stale    = granted && !real_rsp;
        t_valid  = !bus ? 0 : (real_rsp ? g + r + 2 : Tmo);
        t_hs     = t_valid + hold;
        t_rv     = granted ? g + 1 + r : -1;
        last_req = !bus ? -1 : (granted ? g : Tmo - 1);
        end_c    = ((stale && t_rv > t_hs) ? t_rv : t_hs) + 1;
        txn_id++;

        @(negedge clk);
        check("ready_before_accept", dmi_req_ready_o, 1);
        dmi_req_valid_i = 1'b1;
        dmi_req_i.addr  = addr;
        dmi_req_i.op    = dtm_op_e'(op);
        dmi_req_i.data  = data;
        for (int c = 0; c <= end_c; c++) begin
            @(negedge clk);
            check("resp_valid", dmi_resp_valid_o, (c >= t_valid) && (c <= t_hs));
            if (c >= t_valid) check("resp_value", dmi_resp_o, exp);
            check("req_ready", dmi_req_ready_o, (c > t_hs) && (!stale || c > t_rv));
            check("reg_req", reg_req_o, c <= last_req);
            if (c <= last_req)
                check("reg_fields", {reg_we_o, reg_addr_o, reg_wdata_o},
                      {(op == 2'd2), addr, data});
            dmi_req_valid_i  = 1'b0;
            reg_gnt_i        = granted && (c == g);
            reg_rvalid_i     = granted && (c == t_rv);
            reg_rdata_i      = (granted && c == t_rv) ? rdata : $urandom;
            reg_err_i        = (granted && c == t_rv) ? err : 1'($urandom_range(0, 1));
            dmi_resp_ready_i = (c == t_hs);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{op: 2'd1, addr: 7'h11, data: 32'h0, g: 2, r: 0, err: 1'b0,
                    rdata: 32'hDEADBEEF, hold: 0, exp_data: 32'hDEADBEEF, exp_resp: DTM_SUCCESS};
        vecs[1] = '{op: 2'd2, addr: 7'h10, data: 32'h1, g: 0, r: 0, err: 1'b1,
                    rdata: 32'h55AA55AA, hold: 1, exp_data: 32'h0, exp_resp: DTM_ERR};
        vecs[2] = '{op: 2'd1, addr: 7'h05, data: 32'h0, g: 99, r: 0, err: 1'b0,
                    rdata: 32'h0, hold: 0, exp_data: 32'h0, exp_resp: DTM_ERR};
        vecs[3] = '{op: 2'd1, addr: 7'h06, data: 32'h0, g: 0, r: 10, err: 1'b0,
                    rdata: 32'hBAD0BAD0, hold: 0, exp_data: 32'h0, exp_resp: DTM_ERR};
        vecs[4] = '{op: 2'd0, addr: 7'h07, data: 32'h12345678, g: 0, r: 0, err: 1'b0,
                    rdata: 32'h0, hold: 5, exp_data: 32'h0, exp_resp: DTM_SUCCESS};
        vecs[5] = '{op: 2'd3, addr: 7'h08, data: 32'h0, g: 0, r: 0, err: 1'b0,
                    rdata: 32'h0, hold: 0, exp_data: 32'h0, exp_resp: DTM_ERR};
        vecs[6] = '{op: 2'd2, addr: 7'h09, data: 32'hA5A5A5A5, g: 3, r: 0, err: 1'b0,
                    rdata: 32'h11111111, hold: 2, exp_data: 32'h0, exp_resp: DTM_ERR};
        vecs[7] = '{op: 2'd1, addr: 7'h7F, data: 32'h0, g: 1, r: 1, err: 1'b1,
                    rdata: 32'hC0FFEE00, hold: 0, exp_data: 32'hC0FFEE00, exp_resp: DTM_ERR};

        rst_ni           = 1'b0;
        dmi_req_i        = '0;
        dmi_req_valid_i  = 1'b0;
        dmi_resp_ready_i = 1'b0;
        reg_gnt_i        = 1'b0;
        reg_rvalid_i     = 1'b0;
        reg_rdata_i      = '0;
        reg_err_i        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", dmi_req_ready_o, 0);
        check("rst_resp_valid", dmi_resp_valid_o, 0);
        check("rst_resp", dmi_resp_o, 0);
        check("rst_reg_bus", {reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o}, 0);
        rst_ni = 1'b1;
        #1;
        check("ready_after_release", dmi_req_ready_o, 1);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].g, vecs[i].r, vecs[i].err,
                    vecs[i].rdata, vecs[i].hold, '{data: vecs[i].exp_data, resp: vecs[i].exp_resp});
        end

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] rdata;
            logic        err;
            int          g, r;
            op    = 2'($urandom_range(0, 3));
            g     = $urandom_range(0, 5);
            r     = $urandom_range(0, 5);
            err   = 1'($urandom_range(0, 1));
            rdata = $urandom;
            run_txn(op, 7'($urandom), $urandom, g, r, err, rdata, $urandom_range(0, 3),
                    model_resp(op, g, r, err, rdata));
        end

        // Reset while a write waits for its response: abandoned, nothing emitted.
        txn_id++;
        @(negedge clk);
        check("mid_rst_ready_before", dmi_req_ready_o, 1);
        dmi_req_valid_i = 1'b1;
        dmi_req_i       = '{addr: 7'h22, op: DTM_WRITE, data: 32'hCAFE};
        @(negedge clk);
        check("mid_rst_req", reg_req_o, 1);
        dmi_req_valid_i = 1'b0;
        reg_gnt_i       = 1'b1;
        @(negedge clk);
        check("mid_rst_waiting", {reg_req_o, dmi_resp_valid_o}, 0);
        reg_gnt_i = 1'b0;
        rst_ni    = 1'b0;
        #1;
        check("mid_rst_ready_in_reset", dmi_req_ready_o, 0);
        @(negedge clk);
        check("mid_rst_resp_valid", dmi_resp_valid_o, 0);
        check("mid_rst_resp", dmi_resp_o, 0);
        check("mid_rst_reg_bus", {reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o}, 0);
        check("mid_rst_ready", dmi_req_ready_o, 0);
        rst_ni = 1'b1;
        #1;
        check("mid_rst_ready_release", dmi_req_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {dmi_resp_valid_o, reg_req_o, dmi_req_ready_o}, 3'b001);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
